vector_issue_control: RTL

- Registered, multi-beat successor to the combinational opcode decoder.
- Decodes OP/VEC into the same control bundle. Vector ALU and memory ops are issued as ceil(ELEMS/LANES) consecutive beats, each with a beat index and lane mask.
- Uses a valid/ready handshake on both sides.
- Sits between fetch/decode and the execute stage; stalls fetch while a vector op is still beating.

---
 rtl/vector_issue_control_if.sv | 45 ++++
 rtl/vector_issue_control.sv | 128 ++++++++++++
 2 files changed

// File: rtl/vector_issue_control_if.sv
// Issue-stage bus for vector_issue_control: fetch-side instruction handshake
// and execute-side control-beat handshake bundled together.
interface vector_issue_control_if #(
    parameter int ELEMS = 8,
    parameter int LANES = 4
);
    localparam int BEATS  = (ELEMS + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable while valid && !ready.
    logic              IN_VALID;
    logic              IN_READY;
    logic [5:0]        OP;
    logic              VEC;
    logic              FLUSH;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              REG_WRITE;
    logic              MEM_TO_REG;
    logic              MEM_WRITE;
    logic              BRANCH;
    logic              NOT_EQUAL;
    logic [3:0]        ALU_CONTROL;
    logic [1:0]        ALU_SRC;
    logic [BEAT_W-1:0] BEAT;
    logic [LANES-1:0]  LANE_MASK;
    logic              LAST;
    logic              ILLEGAL;
    logic              DBG_STATE;  // 0 = IDLE, 1 = ISSUE

    modport slave (
        input  IN_VALID, OP, VEC, FLUSH, OUT_READY,
        output IN_READY, OUT_VALID, REG_WRITE, MEM_TO_REG, MEM_WRITE, BRANCH,
               NOT_EQUAL, ALU_CONTROL, ALU_SRC, BEAT, LANE_MASK, LAST, ILLEGAL,
               DBG_STATE
    );

    modport master (
        output IN_VALID, OP, VEC, FLUSH, OUT_READY,
        input  IN_READY, OUT_VALID, REG_WRITE, MEM_TO_REG, MEM_WRITE, BRANCH,
               NOT_EQUAL, ALU_CONTROL, ALU_SRC, BEAT, LANE_MASK, LAST, ILLEGAL,
               DBG_STATE
    );
endinterface

// File: rtl/vector_issue_control.sv
// Registered opcode decoder that issues vector ALU/memory ops as a run of
// lane-masked beats and stalls fetch until the last beat is consumed.
module vector_issue_control #(
    parameter int ELEMS = 8,
    parameter int LANES = 4
) (
    input logic                    CLK,
    input logic                    RST,
    vector_issue_control_if.slave  bus
);
    localparam int BEATS    = (ELEMS + LANES - 1) / LANES;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_CNT = ELEMS - LANES * (BEATS - 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [LANES-1:0]  FULL_MASK  = '1;
    localparam logic [LANES-1:0]  TAIL_MASK  = FULL_MASK >> (LANES - LAST_CNT);
    localparam logic [LANES-1:0]  LANE0_MASK = LANES'(1);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       not_equal;
        logic [3:0] alu_control;
        logic [1:0] alu_src;
        logic       illegal;
        logic       multi;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, branch: 1'b0,
        not_equal: 1'b0, alu_control: 4'b1111, alu_src: 2'b01,
        illegal: 1'b0, multi: 1'b0
    };

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    function automatic ctrl_t decode(input logic [5:0] op, input logic vec);
        ctrl_t c;
        c = '0;
        case (op)
            6'b000000: begin c.reg_write = 1'b1; c.alu_control = vec ? 4'b0100 : 4'b0000; c.multi = vec; end
            6'b000001: begin c.reg_write = 1'b1; c.alu_src = 2'b10; end
            6'b000010: begin c.reg_write = 1'b1; c.alu_control = vec ? 4'b0101 : 4'b0001; c.multi = vec; end
            6'b000011: begin c.reg_write = 1'b1; c.alu_control = 4'b0001; c.alu_src = 2'b10; end
            6'b000100: begin c.reg_write = 1'b1; c.alu_control = vec ? 4'b0110 : 4'b0011; c.multi = vec; end
            6'b000101: begin
                c.reg_write = 1'b1; c.alu_control = vec ? 4'b0110 : 4'b0011;
                c.alu_src = 2'b10; c.multi = vec;
            end
            6'b000110: begin c.reg_write = 1'b1; c.alu_control = 4'b0010; end
            6'b000111: begin c.reg_write = 1'b1; c.alu_control = 4'b0111; c.alu_src = 2'b01; end
            6'b001000: begin c.reg_write = 1'b1; c.alu_control = 4'b1000; c.alu_src = 2'b01; end
            6'b001001: begin c.reg_write = 1'b1; c.alu_control = 4'b1001; c.alu_src = 2'b01; end
            6'b001010: begin c.reg_write = 1'b1; c.alu_control = 4'b1010; c.alu_src = 2'b01; end
            6'b001011: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.multi = vec; end
            6'b001100: begin c.mem_write = 1'b1; c.multi = vec; end
            6'b001101: begin c.branch = 1'b1; c.not_equal = 1'b1; end
            6'b010000: begin c.branch = 1'b1; end
            6'b111111: c = NOP_CTRL;
            default:   begin c = NOP_CTRL; c.illegal = 1'b1; end
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic [BEAT_W-1:0] beat_q;
    logic              out_valid, last, in_ready, accept, advance;

    assign out_valid = (state_q == ISSUE);
    assign last      = out_valid && (!ctrl_q.multi || beat_q == LAST_BEAT);
    // Ready while the final beat is leaving so the next op issues without a bubble.
    assign in_ready  = !bus.FLUSH && (!out_valid || (bus.OUT_READY && last));
    assign accept    = bus.IN_VALID && in_ready;
    assign advance   = out_valid && bus.OUT_READY && !last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.FLUSH)                                state_d = IDLE;
        else if (accept)                              state_d = ISSUE;
        else if (out_valid && bus.OUT_READY && last)  state_d = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q <= NOP_CTRL;
            beat_q <= '0;
        end else if (bus.FLUSH) begin
            ctrl_q.illegal <= 1'b0;
            beat_q         <= '0;
        end else if (accept) begin
            ctrl_q <= decode(bus.OP, bus.VEC);
            beat_q <= '0;
        end else if (advance) begin
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    always_comb begin
        bus.IN_READY    = in_ready;
        bus.OUT_VALID   = out_valid;
        bus.REG_WRITE   = ctrl_q.reg_write;
        bus.MEM_TO_REG  = ctrl_q.mem_to_reg;
        bus.MEM_WRITE   = ctrl_q.mem_write;
        bus.BRANCH      = ctrl_q.branch;
        bus.NOT_EQUAL   = ctrl_q.not_equal;
        bus.ALU_CONTROL = ctrl_q.alu_control;
        bus.ALU_SRC     = ctrl_q.alu_src;
        bus.ILLEGAL     = ctrl_q.illegal;
        bus.BEAT        = beat_q;
        bus.LAST        = last;
        bus.DBG_STATE   = state_q;
        bus.LANE_MASK   = '0;
        if (out_valid) begin
            if (!ctrl_q.multi)            bus.LANE_MASK = LANE0_MASK;
            else if (beat_q == LAST_BEAT) bus.LANE_MASK = TAIL_MASK;
            else                          bus.LANE_MASK = FULL_MASK;
        end
    end
endmodule
